// File: rtl/cc_level_loader_pkg.sv
// Shared types and constants for the level loader and the level data handler.
package cc_level_loader_pkg;

    localparam int LEVEL_DATAWIDTH         = 8;
    localparam int CURRENTLEVEL_DATAWIDTH  = 3;
    localparam int LEVELPROGRESS_DATAWIDTH = 5;
    localparam int ROWS                    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IMAGE  = 2'd1,
        ST_SCROLL = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [LEVELPROGRESS_DATAWIDTH-1:0] LEN_IMAGE = 5'd8;
    localparam logic [LEVELPROGRESS_DATAWIDTH-1:0] LEN_LVL1  = 5'd10;
    localparam logic [LEVELPROGRESS_DATAWIDTH-1:0] LEN_LVL2  = 5'd15;
    localparam logic [LEVELPROGRESS_DATAWIDTH-1:0] LEN_LVL3  = 5'd20;

    localparam logic [CURRENTLEVEL_DATAWIDTH-1:0] LVL_IMG1  = 3'd1;
    localparam logic [CURRENTLEVEL_DATAWIDTH-1:0] LVL_LANE1 = 3'd2;
    localparam logic [CURRENTLEVEL_DATAWIDTH-1:0] LVL_IMG2  = 3'd3;
    localparam logic [CURRENTLEVEL_DATAWIDTH-1:0] LVL_LANE2 = 3'd4;
    localparam logic [CURRENTLEVEL_DATAWIDTH-1:0] LVL_IMG3  = 3'd5;
    localparam logic [CURRENTLEVEL_DATAWIDTH-1:0] LVL_LANE3 = 3'd6;

    // Row count of a level; zero marks an invalid level code.
    function automatic logic [LEVELPROGRESS_DATAWIDTH-1:0] level_len(
        input logic [CURRENTLEVEL_DATAWIDTH-1:0] lvl);
        logic [LEVELPROGRESS_DATAWIDTH-1:0] len;
        case (lvl)
            LVL_IMG1, LVL_IMG2, LVL_IMG3: len = LEN_IMAGE;
            LVL_LANE1:                    len = LEN_LVL1;
            LVL_LANE2:                    len = LEN_LVL2;
            LVL_LANE3:                    len = LEN_LVL3;
            default:                      len = 5'd0;
        endcase
        return len;
    endfunction

    function automatic logic level_valid(input logic [CURRENTLEVEL_DATAWIDTH-1:0] lvl);
        return level_len(lvl) != 5'd0;
    endfunction

endpackage

// File: rtl/cc_level_loader_if.sv
// Bundle between the game FSM / data handler / display and the level loader.
interface cc_level_loader_if;
    import cc_level_loader_pkg::*;

    logic                                   CC_LEVEL_LOADER_Start_In;
    logic [CURRENTLEVEL_DATAWIDTH-1:0]      CC_LEVEL_LOADER_Level_In;
    logic                                   CC_LEVEL_LOADER_Tick_In;
    logic [LEVEL_DATAWIDTH-1:0]             CC_LEVEL_LOADER_LevelData_InBus;
    logic [CURRENTLEVEL_DATAWIDTH-1:0]      CC_LEVEL_LOADER_CurrentLvl_OutBus;
    logic [LEVELPROGRESS_DATAWIDTH-1:0]     CC_LEVEL_LOADER_LvlProgress_OutBus;
    logic [ROWS*LEVEL_DATAWIDTH-1:0]        CC_LEVEL_LOADER_Matrix_OutBus;
    logic                                   CC_LEVEL_LOADER_Busy_Out;
    logic                                   CC_LEVEL_LOADER_Done_Out;

    modport slave (
        input  CC_LEVEL_LOADER_Start_In, CC_LEVEL_LOADER_Level_In,
               CC_LEVEL_LOADER_Tick_In, CC_LEVEL_LOADER_LevelData_InBus,
        output CC_LEVEL_LOADER_CurrentLvl_OutBus, CC_LEVEL_LOADER_LvlProgress_OutBus,
               CC_LEVEL_LOADER_Matrix_OutBus, CC_LEVEL_LOADER_Busy_Out,
               CC_LEVEL_LOADER_Done_Out
    );

    modport master (
        output CC_LEVEL_LOADER_Start_In, CC_LEVEL_LOADER_Level_In,
               CC_LEVEL_LOADER_Tick_In, CC_LEVEL_LOADER_LevelData_InBus,
        input  CC_LEVEL_LOADER_CurrentLvl_OutBus, CC_LEVEL_LOADER_LvlProgress_OutBus,
               CC_LEVEL_LOADER_Matrix_OutBus, CC_LEVEL_LOADER_Busy_Out,
               CC_LEVEL_LOADER_Done_Out
    );

endinterface

// File: rtl/cc_level_rowbank.sv
// 8x8 playfield register bank: synchronous clear, indexed row write, shift-in at the top row.
module cc_level_rowbank
    import cc_level_loader_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             clr_i,
    input  logic                             wr_en_i,
    input  logic [2:0]                       wr_idx_i,
    input  logic                             shift_i,
    input  logic [LEVEL_DATAWIDTH-1:0]       data_i,
    output logic [ROWS*LEVEL_DATAWIDTH-1:0]  rows_o
);

    logic [ROWS*LEVEL_DATAWIDTH-1:0] rows_q;

    // Row r lives at [8r+7:8r]; a shift moves every row one place toward row 7.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rows_q <= 64'd0;
        end else if (clr_i) begin
            rows_q <= 64'd0;
        end else if (shift_i) begin
            rows_q <= {rows_q[(ROWS-1)*LEVEL_DATAWIDTH-1:0], data_i};
        end else if (wr_en_i) begin
            rows_q[wr_idx_i*LEVEL_DATAWIDTH +: LEVEL_DATAWIDTH] <= data_i;
        end else begin
            rows_q <= rows_q;
        end
    end

    assign rows_o = rows_q;

endmodule

// File: rtl/cc_level_loader.sv
// Level loader: addresses the level ROM and fills the playfield by burst (odd levels) or per tick (even levels).
module cc_level_loader
    import cc_level_loader_pkg::*;
(
    input  logic               CC_LEVEL_LOADER_CLOCK_50,
    input  logic               CC_LEVEL_LOADER_RESET_InLow,
    cc_level_loader_if.slave   bus
);

    state_e                               state_q;
    logic [CURRENTLEVEL_DATAWIDTH-1:0]    lvl_q;
    logic [LEVELPROGRESS_DATAWIDTH-1:0]   prog_q;
    logic                                 busy_q;
    logic                                 done_q;

    logic                                 start_ok_s;
    logic                                 clr_s;
    logic                                 wr_s;
    logic                                 shift_s;
    logic [2:0]                           wr_idx_s;

    // Row bank strobes, decoded from the current state and the sampled inputs.
    always_comb begin
        start_ok_s = bus.CC_LEVEL_LOADER_Start_In && level_valid(bus.CC_LEVEL_LOADER_Level_In);
        clr_s      = 1'b0;
        wr_s       = 1'b0;
        shift_s    = 1'b0;
        wr_idx_s   = prog_q[2:0] - 3'd1;
        case (state_q)
            ST_IDLE:   clr_s   = start_ok_s;
            ST_IMAGE:  wr_s    = 1'b1;
            ST_SCROLL: shift_s = bus.CC_LEVEL_LOADER_Tick_In;
            default:   clr_s   = 1'b0;
        endcase
    end

    // Sequencer: state, level/progress addresses and registered status flags.
    always_ff @(posedge CC_LEVEL_LOADER_CLOCK_50 or negedge CC_LEVEL_LOADER_RESET_InLow) begin
        if (!CC_LEVEL_LOADER_RESET_InLow) begin
            state_q <= ST_IDLE;
            lvl_q   <= 3'd0;
            prog_q  <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_ok_s) begin
                        lvl_q   <= bus.CC_LEVEL_LOADER_Level_In;
                        prog_q  <= 5'd1;
                        busy_q  <= 1'b1;
                        state_q <= bus.CC_LEVEL_LOADER_Level_In[0] ? ST_IMAGE : ST_SCROLL;
                    end else begin
                        prog_q  <= 5'd0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_IMAGE: begin
                    if (prog_q == LEN_IMAGE) begin
                        prog_q  <= 5'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        prog_q  <= prog_q + 5'd1;
                    end
                end
                ST_SCROLL: begin
                    // Equality stop keeps progress from ever running past the level length.
                    if (bus.CC_LEVEL_LOADER_Tick_In && (prog_q == level_len(lvl_q))) begin
                        prog_q  <= 5'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (bus.CC_LEVEL_LOADER_Tick_In) begin
                        prog_q  <= prog_q + 5'd1;
                    end else begin
                        prog_q  <= prog_q;
                    end
                end
                ST_DONE: begin
                    prog_q  <= 5'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    prog_q  <= 5'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    cc_level_rowbank u_rowbank (
        .clk_i    (CC_LEVEL_LOADER_CLOCK_50),
        .rst_n_i  (CC_LEVEL_LOADER_RESET_InLow),
        .clr_i    (clr_s),
        .wr_en_i  (wr_s),
        .wr_idx_i (wr_idx_s),
        .shift_i  (shift_s),
        .data_i   (bus.CC_LEVEL_LOADER_LevelData_InBus),
        .rows_o   (bus.CC_LEVEL_LOADER_Matrix_OutBus)
    );

    assign bus.CC_LEVEL_LOADER_CurrentLvl_OutBus  = lvl_q;
    assign bus.CC_LEVEL_LOADER_LvlProgress_OutBus = prog_q;
    assign bus.CC_LEVEL_LOADER_Busy_Out           = busy_q;
    assign bus.CC_LEVEL_LOADER_Done_Out           = done_q;

endmodule

// File: tb/tb_cc_level_loader.sv
// Self-checking bench for cc_level_loader with a behavioural level data handler and playfield model.
module tb_cc_level_loader;
    import cc_level_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cc_level_loader_if bus();

    cc_level_loader dut (
        .CC_LEVEL_LOADER_CLOCK_50    (clk),
        .CC_LEVEL_LOADER_RESET_InLow (rst_n),
        .bus                         (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    typedef struct {
        int          lv;
        int          ticks;
        logic [63:0] exp;
    } vec_t;

    // Level data handler: row tables addressed by (level, 1-based progress).
    function automatic logic [7:0] rom(int lv, int p);
        logic [7:0] v;
        v = 8'h00;
        if (p >= 1) begin
            case (lv)
                1: case (p)
                       1: v = 8'h18; 2: v = 8'h78; 3: v = 8'hD8; 4, 5, 6, 7: v = 8'h18; 8: v = 8'hFF;
                       default: v = 8'h00;
                   endcase
                2: case (p)
                       1: v = 8'h81; 2: v = 8'h42; 3: v = 8'h20; 4: v = 8'h10; 5: v = 8'h40;
                       6, 7, 8: v = 8'h20; 9: v = 8'h10; 10: v = 8'h40;
                       default: v = 8'h00;
                   endcase
                3: case (p)
                       1: v = 8'h3C; 2: v = 8'h66; 3: v = 8'h06; 4: v = 8'h1C;
                       5: v = 8'h06; 6: v = 8'h06; 7: v = 8'h66; 8: v = 8'h3C;
                       default: v = 8'h00;
                   endcase
                4: if (p <= 15) v = 8'(8'h03 << (p % 7));
                5: case (p)
                       1: v = 8'h7E; 2: v = 8'h60; 3: v = 8'h7C; 4: v = 8'h06;
                       5: v = 8'h06; 6: v = 8'h06; 7: v = 8'h66; 8: v = 8'h3C;
                       default: v = 8'h00;
                   endcase
                6: if (p <= 20) v = 8'(8'hE0 >> (p % 6)) ^ 8'h01;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    always_comb bus.CC_LEVEL_LOADER_LevelData_InBus =
        rom(int'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), int'(bus.CC_LEVEL_LOADER_LvlProgress_OutBus));

    function automatic int model_len(int lv);
        case (lv)
            1, 3, 5: return 8;
            2:       return 10;
            4:       return 15;
            6:       return 20;
            default: return 0;
        endcase
    endfunction

    // Playfield after n rows fetched: images fill top-down, lanes push newest row into row 0.
    function automatic logic [63:0] model_matrix(int lv, int n);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (lv % 2 == 1) m[i*8 +: 8] = (i < n) ? rom(lv, i + 1) : 8'h00;
            else             m[i*8 +: 8] = (n - i >= 1) ? rom(lv, n - i) : 8'h00;
        end
        return m;
    endfunction

    always @(negedge clk) if (bus.CC_LEVEL_LOADER_Done_Out === 1'b1) done_cnt++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start(int lv);
        bus.CC_LEVEL_LOADER_Start_In = 1'b1;
        bus.CC_LEVEL_LOADER_Level_In = 3'(lv);
        step();
        bus.CC_LEVEL_LOADER_Start_In = 1'b0;
    endtask

    task automatic check_status(string name, int busy, int done, int prog);
        chk({name, "_busy"}, 64'(bus.CC_LEVEL_LOADER_Busy_Out), 64'(busy));
        chk({name, "_done"}, 64'(bus.CC_LEVEL_LOADER_Done_Out), 64'(done));
        chk({name, "_prog"}, 64'(bus.CC_LEVEL_LOADER_LvlProgress_OutBus), 64'(prog));
    endtask

    // Burst load with random (ignored) ticks; optionally fire a Start in the Done cycle.
    task automatic run_image(int lv, bit start_on_done);
        pulse_start(lv);
        check_status("img_start", 1, 0, 1);
        chk("img_lvl", 64'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), 64'(lv));
        chk("img_clear", bus.CC_LEVEL_LOADER_Matrix_OutBus, 64'd0);
        for (int j = 1; j < 8; j++) begin
            bus.CC_LEVEL_LOADER_Tick_In = 1'($urandom_range(0, 1));
            step();
            check_status("img_run", 1, 0, j + 1);
            chk("img_partial", bus.CC_LEVEL_LOADER_Matrix_OutBus, model_matrix(lv, j));
        end
        bus.CC_LEVEL_LOADER_Tick_In = 1'b0;
        step();
        check_status("img_donecyc", 0, 1, 0);
        chk("img_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, model_matrix(lv, 8));
        if (start_on_done) begin
            pulse_start(5);
            check_status("img_start_in_done", 0, 0, 0);
            chk("img_start_in_done_lvl", 64'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), 64'(lv));
        end else begin
            step();
            check_status("img_idle", 0, 0, 0);
        end
    endtask

    // Tick-driven load of nticks ticks with random gaps; optional Start during SCROLL.
    task automatic run_scroll(int lv, int nticks, bit extra_start);
        int len;
        int gap;
        int cnt0;
        len  = model_len(lv);
        cnt0 = done_cnt;
        pulse_start(lv);
        check_status("scr_start", 1, 0, 1);
        chk("scr_clear", bus.CC_LEVEL_LOADER_Matrix_OutBus, 64'd0);
        for (int t = 1; t <= nticks; t++) begin
            gap = (extra_start && t == 4) ? 2 : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                if (extra_start && t == 4 && g == 0) pulse_start(3);
                else step();
            end
            if (gap > 0) begin
                check_status("scr_hold", 1, 0, t);
                chk("scr_hold_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, model_matrix(lv, t - 1));
                chk("scr_hold_lvl", 64'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), 64'(lv));
            end
            bus.CC_LEVEL_LOADER_Tick_In = 1'b1;
            step();
            bus.CC_LEVEL_LOADER_Tick_In = 1'b0;
            if (t < len) check_status("scr_tick", 1, 0, t + 1);
            else         check_status("scr_donecyc", 0, 1, 0);
            chk("scr_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, model_matrix(lv, t));
        end
        if (nticks == len) begin
            step();
            check_status("scr_idle", 0, 0, 0);
            chk("scr_done_count", 64'(done_cnt - cnt0), 64'd1);
        end
    endtask

    task automatic check_reset_state(string name);
        check_status(name, 0, 0, 0);
        chk({name, "_lvl"}, 64'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), 64'd0);
        chk({name, "_rows"}, bus.CC_LEVEL_LOADER_Matrix_OutBus, 64'd0);
    endtask

    task automatic pulse_reset(string name);
        #2 rst_n = 1'b0;
        #1 check_reset_state(name);
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vec_t        tbl[6];
        logic [63:0] exp_mat;
        int          exp_lvl;
        int          lv;
        int          cnt0;

        tbl[0] = '{1, 0, 64'hFF18181818D87818};
        tbl[1] = '{2, 10, 64'h2010402020201040};
        tbl[2] = '{0, 0, 64'd0};
        tbl[3] = '{3, 0, model_matrix(3, 8)};
        tbl[4] = '{7, 0, 64'd0};
        tbl[5] = '{5, 0, model_matrix(5, 8)};

        bus.CC_LEVEL_LOADER_Start_In = 1'b0;
        bus.CC_LEVEL_LOADER_Level_In = 3'd0;
        bus.CC_LEVEL_LOADER_Tick_In  = 1'b0;
        step();
        step();
        check_reset_state("reset");
        rst_n = 1'b1;
        step();
        check_reset_state("after_release");

        exp_mat = 64'd0;
        exp_lvl = 0;
        for (int k = 0; k < 6; k++) begin
            if (tbl[k].lv == 0 || tbl[k].lv == 7) begin
                cnt0 = done_cnt;
                pulse_start(tbl[k].lv);
                bus.CC_LEVEL_LOADER_Tick_In = 1'b1;
                step();
                bus.CC_LEVEL_LOADER_Tick_In = 1'b0;
                check_status("bad_level", 0, 0, 0);
                chk("bad_level_lvl", 64'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), 64'(exp_lvl));
                chk("bad_level_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, exp_mat);
                chk("bad_level_nodone", 64'(done_cnt - cnt0), 64'd0);
            end else begin
                if (tbl[k].ticks == 0) run_image(tbl[k].lv, k == 0);
                else                   run_scroll(tbl[k].lv, tbl[k].ticks, 1'b1);
                exp_mat = tbl[k].exp;
                exp_lvl = tbl[k].lv;
                chk("table_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, exp_mat);
            end
        end

        step();
        pulse_reset("reset_idle");

        run_scroll(4, 5, 1'b0);
        pulse_reset("reset_scroll");
        run_image(3, 1'b0);

        run_scroll(6, 20, 1'b0);
        cnt0 = done_cnt;
        for (int x = 0; x < 3; x++) begin
            bus.CC_LEVEL_LOADER_Tick_In = 1'b1;
            step();
            bus.CC_LEVEL_LOADER_Tick_In = 1'b0;
            step();
        end
        check_status("extra_ticks", 0, 0, 0);
        chk("extra_ticks_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, model_matrix(6, 20));
        chk("extra_ticks_nodone", 64'(done_cnt - cnt0), 64'd0);

        for (int r = 0; r < 8; r++) begin
            lv = int'($urandom_range(1, 6));
            if (lv % 2 == 1) run_image(lv, 1'b0);
            else             run_scroll(lv, model_len(lv), 1'b0);
            chk("rand_rows", bus.CC_LEVEL_LOADER_Matrix_OutBus, model_matrix(lv, model_len(lv)));
            chk("rand_lvl", 64'(bus.CC_LEVEL_LOADER_CurrentLvl_OutBus), 64'(lv));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
